// File: rtl/cache_pkg.sv
// Shared command codes, FSM encoding and sizing helper for the block server.
package cache_pkg;

  localparam logic [2:0] CMD_READ_BLOCK  = 3'd1;
  localparam logic [2:0] CMD_WRITE_BLOCK = 3'd2;
  localparam logic [2:0] CMD_FILL_BLOCK  = 3'd3;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    WRITE_WORDS = 3'd1,
    READ_ISSUE  = 3'd2,
    READ_WAIT   = 3'd3,
    RESPOND     = 3'd4
  } state_t;

  function automatic int CLOG2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/memory_block_server.sv
// Serialises one block read/write-back into word transactions; write takes 1 cycle/word, read 2 cycles/word + respond.
// Back-pressure: req_full_o high outside IDLE; words held until mem_ready_i; fill held while rsp_full_i.
module memory_block_server
  import cache_pkg::*;
#(
  parameter int BW_USED_ADDR_WORD     = 24,
  parameter int BW_DATA_WORD          = 32,
  parameter int BW_DATA_EXTERNAL_BUS  = 512,
  parameter int BW_CACHE_COMMAND      = 3,
  parameter int CACHE_WORDS_PER_BLOCK = 16
) (
  input  logic                            clock_i,
  input  logic                            reset_i,

  input  logic                            req_write_i,
  input  logic [BW_CACHE_COMMAND-1:0]     req_command_i,
  input  logic [BW_USED_ADDR_WORD-1:0]    req_addr_i,
  input  logic [BW_DATA_EXTERNAL_BUS-1:0] req_data_i,
  output logic                            req_full_o,

  output logic                            rsp_write_o,
  output logic [BW_CACHE_COMMAND-1:0]     rsp_command_o,
  output logic [BW_USED_ADDR_WORD-1:0]    rsp_addr_o,
  output logic [BW_DATA_EXTERNAL_BUS-1:0] rsp_data_o,
  input  logic                            rsp_full_i,

  output logic                            mem_request_o,
  output logic                            mem_wren_o,
  output logic [BW_USED_ADDR_WORD-1:0]    mem_addr_o,
  output logic [BW_DATA_WORD-1:0]         mem_data_o,
  input  logic                            mem_ready_i,
  input  logic                            mem_valid_i,
  input  logic [BW_DATA_WORD-1:0]         mem_data_i
);

  localparam int BW_CNT = CLOG2(CACHE_WORDS_PER_BLOCK);
  localparam logic [BW_CNT-1:0] LAST_WORD = BW_CNT'(CACHE_WORDS_PER_BLOCK - 1);
  localparam logic [BW_USED_ADDR_WORD-1:0] OFFSET_MASK =
    BW_USED_ADDR_WORD'(CACHE_WORDS_PER_BLOCK - 1);

  state_t                                         state;
  logic [BW_CNT-1:0]                              word_cnt;
  logic [BW_USED_ADDR_WORD-1:0]                   base_addr;
  logic [BW_CACHE_COMMAND-1:0]                    rsp_command;
  // One line register: write-back source on the way out, fill assembly on the way in.
  logic [CACHE_WORDS_PER_BLOCK-1:0][BW_DATA_WORD-1:0] line;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= IDLE;
      word_cnt    <= '0;
      base_addr   <= '0;
      rsp_command <= '0;
      line        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_write_i) begin
            base_addr <= req_addr_i & ~OFFSET_MASK;
            line      <= req_data_i;
            word_cnt  <= '0;
            if (req_command_i == BW_CACHE_COMMAND'(CMD_WRITE_BLOCK))
              state <= WRITE_WORDS;
            else if (req_command_i == BW_CACHE_COMMAND'(CMD_READ_BLOCK))
              state <= READ_ISSUE;
          end
        end
        WRITE_WORDS: begin
          if (mem_ready_i) begin
            word_cnt <= word_cnt + 1'b1;
            if (word_cnt == LAST_WORD) state <= IDLE;
          end
        end
        READ_ISSUE: begin
          if (mem_ready_i) state <= READ_WAIT;
        end
        READ_WAIT: begin
          if (mem_valid_i) begin
            line[word_cnt] <= mem_data_i;
            if (word_cnt == LAST_WORD) begin
              state       <= RESPOND;
              rsp_command <= BW_CACHE_COMMAND'(CMD_FILL_BLOCK);
            end else begin
              word_cnt <= word_cnt + 1'b1;
              state    <= READ_ISSUE;
            end
          end
        end
        RESPOND: begin
          if (!rsp_full_i) begin
            state       <= IDLE;
            rsp_command <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_full_o    = (state != IDLE);
  assign mem_request_o = (state == WRITE_WORDS) || (state == READ_ISSUE);
  assign mem_wren_o    = (state == WRITE_WORDS);
  assign mem_addr_o    = base_addr | BW_USED_ADDR_WORD'(word_cnt);
  assign mem_data_o    = line[word_cnt];

  assign rsp_write_o   = (state == RESPOND) && !rsp_full_i;
  assign rsp_command_o = rsp_command;
  assign rsp_addr_o    = base_addr;
  assign rsp_data_o    = line;

endmodule

// File: tb/tb_memory_block_server.sv
// Directed bench for memory_block_server: behavioural transaction model, emulated 1-cycle memory, per-cycle compare.
module tb_memory_block_server;

  typedef struct packed {
    logic        wren;
    logic [23:0] addr;
    logic [31:0] data;
  } txn_t;

  typedef struct packed {
    logic [23:0]  addr;
    logic [511:0] line;
  } rsp_t;

  logic         clk = 1'b0;
  logic         reset_i = 1'b1;
  logic         req_write = 1'b0;
  logic [2:0]   req_command = '0;
  logic [23:0]  req_addr = '0;
  logic [511:0] req_data = '0;
  logic         req_full_o;
  logic         rsp_write_o;
  logic [2:0]   rsp_command_o;
  logic [23:0]  rsp_addr_o;
  logic [511:0] rsp_data_o;
  logic         rsp_full = 1'b0;
  logic         mem_request_o;
  logic         mem_wren_o;
  logic [23:0]  mem_addr_o;
  logic [31:0]  mem_data_o;
  logic         mem_ready_i = 1'b1;
  logic         mem_valid_i = 1'b0;
  logic [31:0]  mem_data_i = '0;

  int tests = 0;
  int failed = 0;
  int rsp_seen = 0;
  int vld_cnt = 0;
  logic         ready_mode = 1'b0;
  logic         tgl = 1'b0;
  logic         rd_acc = 1'b0;
  logic [23:0]  rd_addr = '0;
  logic [23:0]  last_rsp_addr = '0;
  logic [511:0] last_rsp_line = '0;

  txn_t exp_mem[$];
  rsp_t exp_rsp[$];

  memory_block_server dut (
    .clock_i(clk), .reset_i(reset_i),
    .req_write_i(req_write), .req_command_i(req_command), .req_addr_i(req_addr),
    .req_data_i(req_data), .req_full_o(req_full_o),
    .rsp_write_o(rsp_write_o), .rsp_command_o(rsp_command_o), .rsp_addr_o(rsp_addr_o),
    .rsp_data_o(rsp_data_o), .rsp_full_i(rsp_full),
    .mem_request_o(mem_request_o), .mem_wren_o(mem_wren_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_ready_i(mem_ready_i), .mem_valid_i(mem_valid_i),
    .mem_data_i(mem_data_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_line(input string name, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    failed++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: what a block command must turn into on the memory and response ports.
  task automatic model_req(input logic [2:0] cmd, input logic [23:0] addr, input logic [511:0] ln);
    logic [23:0] base;
    txn_t t;
    rsp_t r;
    base = addr & ~24'hF;
    r = '0;
    if (cmd == 3'd2) begin
      for (int i = 0; i < 16; i++) begin
        t.wren = 1'b1; t.addr = base + 24'(i); t.data = ln[32*i +: 32];
        exp_mem.push_back(t);
      end
    end else if (cmd == 3'd1) begin
      for (int i = 0; i < 16; i++) begin
        t.wren = 1'b0; t.addr = base + 24'(i); t.data = '0;
        exp_mem.push_back(t);
        r.line[32*i +: 32] = {8'h00, base + 24'(i)} ^ 32'h5A5A5A5A;
      end
      r.addr = base;
      exp_rsp.push_back(r);
    end
  endtask

  task automatic send(input logic [2:0] cmd, input logic [23:0] addr, input logic [511:0] ln);
    int n;
    n = 0;
    req_write = 1'b1; req_command = cmd; req_addr = addr; req_data = ln;
    @(negedge clk);
    while (req_full_o && n < 200) begin
      step();
      @(negedge clk);
      n++;
    end
    if (req_full_o) flag_fail("send_timeout");
    step();
    req_write = 1'b0;
    model_req(cmd, addr, ln);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (req_full_o && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (req_full_o) flag_fail("idle_timeout");
    step();
    chk("mem_drained", 32'(exp_mem.size()), 32'd0);
    chk("rsp_drained", 32'(exp_rsp.size()), 32'd0);
  endtask

  // Memory emulator: accepts reads when ready, answers addr^0x5A5A5A5A one cycle later.
  always @(negedge clk) begin
    rd_acc  <= mem_request_o && mem_ready_i && !mem_wren_o;
    rd_addr <= mem_addr_o;
    if (mem_valid_i) vld_cnt++;
  end

  always @(posedge clk) begin
    #1;
    mem_valid_i = rd_acc;
    mem_data_i  = {8'h00, rd_addr} ^ 32'h5A5A5A5A;
    tgl = ~tgl;
    mem_ready_i = ready_mode ? tgl : 1'b1;
  end

  always @(negedge clk) begin
    if (!reset_i) begin
      if (mem_request_o) begin
        if (exp_mem.size() == 0) flag_fail("mem_unexpected");
        else begin
          chk("mem_wren", 32'(mem_wren_o), 32'(exp_mem[0].wren));
          chk("mem_addr", 32'(mem_addr_o), 32'(exp_mem[0].addr));
          if (exp_mem[0].wren) chk("mem_data", mem_data_o, exp_mem[0].data);
          if (mem_ready_i) void'(exp_mem.pop_front());
        end
      end
      if (rsp_write_o) begin
        rsp_seen++;
        last_rsp_addr = rsp_addr_o;
        last_rsp_line = rsp_data_o;
        if (exp_rsp.size() == 0) flag_fail("rsp_unexpected");
        else begin
          chk("rsp_cmd", 32'(rsp_command_o), 32'd3);
          chk("rsp_addr", 32'(rsp_addr_o), 32'(exp_rsp[0].addr));
          chk_line("rsp_data", rsp_data_o, exp_rsp[0].line);
          void'(exp_rsp.pop_front());
        end
      end
    end
  end

  initial begin
    logic [511:0] wl;
    rsp_t r_exp;
    int cnt;
    int lat;
    int n;
    int seen0;

    // Reset state
    repeat (3) step();
    @(negedge clk);
    chk("rst_req_full", 32'(req_full_o), 32'd0);
    chk("rst_rsp_write", 32'(rsp_write_o), 32'd0);
    chk("rst_rsp_cmd", 32'(rsp_command_o), 32'd0);
    chk("rst_rsp_addr", 32'(rsp_addr_o), 32'd0);
    chk_line("rst_rsp_data", rsp_data_o, 512'd0);
    chk("rst_mem_req", 32'(mem_request_o), 32'd0);
    chk("rst_mem_wren", 32'(mem_wren_o), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    chk("rst_mem_data", mem_data_o, 32'd0);
    step();
    reset_i = 1'b0;
    step();

    // Write-back, memory always ready
    for (int i = 0; i < 16; i++) wl[32*i +: 32] = 32'hA0000000 + 32'(i);
    seen0 = rsp_seen;
    send(3'd2, 24'h001234, wl);
    cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      if (mem_request_o) cnt++;
      step();
    end
    @(negedge clk);
    chk("wr_req_cycles", 32'(cnt), 32'd16);
    chk("wr_full_after16", 32'(req_full_o), 32'd0);
    chk("wr_no_rsp", 32'(rsp_seen), 32'(seen0));
    wait_idle();

    // Block read at 0x000047
    send(3'd1, 24'h000047, '0);
    lat = 1;
    @(negedge clk);
    while (!rsp_write_o && lat < 100) begin
      step();
      @(negedge clk);
      lat++;
    end
    chk("rd_latency", 32'(lat), 32'd33);
    wait_idle();
    chk("rd_addr_lit", 32'(last_rsp_addr), 32'h000040);
    chk("rd_word7_lit", last_rsp_line[7*32 +: 32], 32'h5A5A5A1D);
    chk("rd_word0_lit", last_rsp_line[31:0], 32'h5A5A5A1A);

    // Fill held by rsp_full_i
    rsp_full = 1'b1;
    send(3'd1, 24'h000100, '0);
    r_exp = exp_rsp[0];
    n = 0;
    while (exp_mem.size() != 0 && n < 200) begin
      step();
      n++;
    end
    repeat (2) step();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("hold_rsp_write", 32'(rsp_write_o), 32'd0);
      chk("hold_req_full", 32'(req_full_o), 32'd1);
      chk("hold_rsp_addr", 32'(rsp_addr_o), 32'h000100);
      chk_line("hold_rsp_data", rsp_data_o, r_exp.line);
      step();
    end
    seen0 = rsp_seen;
    rsp_full = 1'b0;
    wait_idle();
    chk("hold_rsp_once", 32'(rsp_seen), 32'(seen0 + 1));

    // Write with ready toggling
    ready_mode = 1'b1;
    for (int i = 0; i < 16; i++) wl[32*i +: 32] = 32'hB0000000 + 32'(i);
    send(3'd2, 24'h000200, wl);
    wait_idle();
    ready_mode = 1'b0;

    // Illegal command followed back-to-back by a read
    send(3'd7, 24'h000500, '1);
    req_write = 1'b1; req_command = 3'd1; req_addr = 24'h000600; req_data = '0;
    @(negedge clk);
    chk("cmd7_full", 32'(req_full_o), 32'd0);
    chk("cmd7_no_traffic", 32'(mem_request_o), 32'd0);
    step();
    req_write = 1'b0;
    model_req(3'd1, 24'h000600, '0);
    @(negedge clk);
    chk("cmd7_read_starts", 32'(mem_request_o), 32'd1);
    wait_idle();

    // Reset mid-read after word 5 returns, then a fresh read at 0x000040
    vld_cnt = 0;
    send(3'd1, 24'h000300, '0);
    n = 0;
    while (vld_cnt < 6 && n < 200) begin
      step();
      n++;
    end
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    exp_mem.delete();
    exp_rsp.delete();
    @(negedge clk);
    chk("midrst_mem_req", 32'(mem_request_o), 32'd0);
    chk("midrst_req_full", 32'(req_full_o), 32'd0);
    step();
    seen0 = rsp_seen;
    send(3'd1, 24'h000040, '0);
    wait_idle();
    chk("midrst_one_rsp", 32'(rsp_seen), 32'(seen0 + 1));
    chk("midrst_addr_lit", 32'(last_rsp_addr), 32'h000040);
    chk("midrst_word15_lit", last_rsp_line[15*32 +: 32], 32'h5A5A5A15);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/memory_block_server.md
# memory_block_server

Downstream stage of the level-1 cache's outgoing request port. It accepts one block-level command at a time (block read or block write-back, 512-bit line). It serialises the command into word-wide transactions on a simple main-memory port. For reads, it reassembles the returned words and pushes a fill response back into the cache's incoming request buffer. It is the terminal "next level" for a single-level configuration.

## Interface
Parameters:
- BW_USED_ADDR_WORD, 24, word-address width shared with the cache.
- BW_DATA_WORD, 32, memory word width.
- BW_DATA_EXTERNAL_BUS, 512, block bus width; must equal BW_DATA_WORD*CACHE_WORDS_PER_BLOCK.
- BW_CACHE_COMMAND, 3, command field width.
- CACHE_WORDS_PER_BLOCK, 16, words per block; power of two.

Ports:
- Clocking: one clock; reset is synchronous and active-high.
  - clock_i, in, 1, sole clock.
  - reset_i, in, 1, synchronous reset, active-high.
- Request input, from the cache outgoing port:
  - req_write_i, in, 1, request strobe.
  - req_command_i, in, BW_CACHE_COMMAND, CMD_READ_BLOCK or CMD_WRITE_BLOCK.
  - req_addr_i, in, BW_USED_ADDR_WORD, word address inside the target block.
  - req_data_i, in, BW_DATA_EXTERNAL_BUS, write-back line.
  - req_full_o, out, 1, block busy; requests are refused.
- Response output, to the cache incoming buffer:
  - rsp_write_o, out, 1, fill strobe.
  - rsp_command_o, out, BW_CACHE_COMMAND, CMD_FILL_BLOCK.
  - rsp_addr_o, out, BW_USED_ADDR_WORD, block-aligned address.
  - rsp_data_o, out, BW_DATA_EXTERNAL_BUS, fill line.
  - rsp_full_i, in, 1, cache buffer full.
- Memory port:
  - mem_request_o, out, 1, word transaction request.
  - mem_wren_o, out, 1, 1 = write, 0 = read.
  - mem_addr_o, out, BW_USED_ADDR_WORD, word address.
  - mem_data_o, out, BW_DATA_WORD, write word.
  - mem_ready_i, in, 1, memory accepts the request this cycle.
  - mem_valid_i, in, 1, read data valid.
  - mem_data_i, in, BW_DATA_WORD, read word.

## Operation
- FSM states: IDLE, WRITE_WORDS, READ_ISSUE, READ_WAIT, RESPOND.
- IDLE:
  - A request is accepted when req_write_i is high and req_full_o is low.
  - On acceptance, the command is latched, and the address is latched with its low log2(CACHE_WORDS_PER_BLOCK) bits forced to 0.
  - The data line is latched and the word counter is cleared.
- Command decode:
  - CMD_WRITE_BLOCK goes to WRITE_WORDS.
  - CMD_READ_BLOCK goes to READ_ISSUE.
  - Any other code is dropped, with no memory or response activity, and the FSM stays in IDLE.
- Word mapping:
  - Word i lives at line bits [BW_DATA_WORD*i +: BW_DATA_WORD].
  - Its address is base | i.
  - The counter is log2(CACHE_WORDS_PER_BLOCK) bits wide and wraps only at the terminal word.
- WRITE_WORDS:
  - Outputs: mem_request_o=1, mem_wren_o=1, and the counter-selected address and word.
  - When mem_ready_i is high, the counter increments.
  - After the last word is accepted, the FSM goes to IDLE; no response is generated.
- READ_ISSUE:
  - Outputs: mem_request_o=1, mem_wren_o=0.
  - When mem_ready_i is high, the FSM goes to READ_WAIT.
- READ_WAIT:
  - mem_request_o=0.
  - When mem_valid_i is high, mem_data_i is written into line slot i.
  - If i is the last word, the FSM goes to RESPOND; otherwise the counter increments and the FSM returns to READ_ISSUE.
- RESPOND:
  - rsp_write_o equals !rsp_full_i; rsp_addr_o is the base address; rsp_data_o is the assembled line.
  - The FSM goes to IDLE in the cycle rsp_write_o is high.
- req_full_o is high in every state other than IDLE.
- Only one memory transaction is outstanding at any time. A mem_valid_i arriving outside READ_WAIT is ignored.

## Timing
- Reset values: FSM in IDLE, counter 0. All outputs are 0: req_full_o, rsp_write_o, rsp_command_o, rsp_addr_o, rsp_data_o, mem_request_o, mem_wren_o, mem_addr_o, mem_data_o.
- Reset mid-operation: the command is abandoned with no response issued; mem_request_o is 0 from the first cycle after the reset edge.
- Acceptance edge: at edge T the request is accepted, and req_full_o rises after T.
- Write-back latency: with mem_ready_i held high, mem_request_o is high in cycles T+1 to T+16, and req_full_o falls after the edge that ends cycle T+16.
- Read latency:
  - mem_valid_i arrives no earlier than the cycle after acceptance.
  - With 1-cycle memory, each word takes 2 cycles; rsp_write_o is first high in cycle T+33 when rsp_full_i is low.
- rsp_full_i held high: the FSM stays in RESPOND with outputs stable and rsp_write_o low.
- A new request in the same cycle RESPOND completes is refused, because req_full_o is still high. It is accepted on the next cycle.
- mem_request_o, mem_wren_o and rsp_write_o are combinational from state and the handshake inputs. All data and address outputs come from registers.

## Structure
- Package cache_pkg holds:
  - CMD_READ_BLOCK = 3'd1, CMD_WRITE_BLOCK = 3'd2, CMD_FILL_BLOCK = 3'd3;
  - the FSM state encoding;
  - the CLOG2 helper.
- The block is a single module with no sub-modules. The line register is shared between the write source and the read assembly.

## Test plan
- Reset mid-read (after word 5 has returned), then a new read at 0x000040: no response for the abandoned read; the new fill is correct and addressed 0x000040.
- CMD_WRITE_BLOCK at 0x001234 with line word i = 0xA0000000+i, mem_ready_i=1: 16 writes to 0x001230–0x00123F in order, data 0xA0000000–0xA000000F, no rsp_write_o, req_full_o low after 16 cycles.
- CMD_READ_BLOCK at 0x000047 with memory returning addr^0x5A5A5A5A at 1-cycle latency: reads of 0x000040–0x00004F; single rsp_write_o with CMD_FILL_BLOCK, address 0x000040, every word correct.
- Read with rsp_full_i high for 10 cycles at the fill point: response held stable, emitted once on release, then req_full_o low.
- Write with mem_ready_i toggling 1,0,1,0: each word is presented until accepted; no word is skipped or duplicated.
- Command 3'd7, then a back-to-back read: the 3'd7 command produces no memory traffic, and the read starts in the following cycle.
